gshare_bp_spec: RTL

//  Parametrised gshare direction predictor for the fetch stage, with a speculative global history.

---
 rtl/gshare_pkg.sv | 36 +++
 rtl/gshare_bht.sv | 38 +++
 rtl/gshare_bp_spec.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare predictor: counter type, counter init value,
// saturating counter update and BHT index hash.
package gshare_pkg;

  localparam int unsigned CTR_MAX_BITS = 8;
  localparam int unsigned CTR_BITS_DEF = 2;

  // Wide enough for any supported CTR_BITS; narrower counters are zero-extended.
  typedef logic [CTR_MAX_BITS-1:0] ctr_t;

  localparam ctr_t CTR_INIT = ctr_t'((32'd1 << (CTR_BITS_DEF - 1)) - 32'd1);

  // Weakly not-taken value for a counter of the given width.
  function automatic ctr_t ctr_init(input int unsigned bits);
    return ctr_t'((32'd1 << (bits - 1)) - 32'd1);
  endfunction

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken,
                                      input int unsigned bits);
    ctr_t max_v;
    max_v = ctr_t'((32'd1 << bits) - 32'd1);
    if (taken) begin
      return (ctr == max_v) ? ctr : ctr + ctr_t'(1);
    end
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

  // pc[idx_bits+1:2] XOR zero-extended history, returned in the low idx_bits.
  function automatic logic [31:0] gshare_index(input logic [31:0] pc, input logic [31:0] ghr,
                                               input int unsigned idx_bits);
    logic [31:0] mask;
    mask = (32'd1 << idx_bits) - 32'd1;
    return ((pc >> 2) ^ ghr) & mask;
  endfunction

endpackage

// File: rtl/gshare_bht.sv
// Branch history table: saturating counters with one async read port (MSB only) and one
// sync read-modify-write update port. Asynchronous active-high reset loads the init value.
module gshare_bht
  import gshare_pkg::*;
#(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int unsigned Entries = 32'd1 << IDX_BITS;
  localparam ctr_t InitVal = (CTR_BITS == CTR_BITS_DEF) ? CTR_INIT : ctr_init(CTR_BITS);

  logic [CTR_BITS-1:0] mem_q [Entries];
  ctr_t                wr_next;

  assign wr_next  = sat_update(ctr_t'(mem_q[wr_idx]), wr_taken, CTR_BITS);
  // Read sees the stored value, so a same-cycle update is not visible (read-before-write).
  assign rd_taken = mem_q[rd_idx][CTR_BITS-1];

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < int'(Entries); i++) begin
        mem_q[i] <= CTR_BITS'(InitVal);
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= CTR_BITS'(wr_next);
    end
  end

endmodule

// File: rtl/gshare_bp_spec.sv
// gshare direction predictor with speculative/architectural global history and repair.
// Optional perf counters are built when GSHARE_PERF_CNT_EN is defined.
module gshare_bp_spec
  import gshare_pkg::*;
#(
  parameter int unsigned GHR_BITS = 8,
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                rsp_valid,
  output logic                rsp_taken,
  output logic [IDX_BITS-1:0] rsp_idx,
  output logic [GHR_BITS-1:0] rsp_ghr,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  input  logic                flush
`ifdef GSHARE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispred
`endif
);

  if (GHR_BITS > IDX_BITS) begin : g_ghr_chk
    $error("GHR_BITS must not exceed IDX_BITS");
  end
  if (CTR_BITS < 1 || CTR_BITS > CTR_MAX_BITS) begin : g_ctr_chk
    $error("CTR_BITS out of range");
  end

  logic [IDX_BITS-1:0] pred_idx;
  logic                pred_taken;
  logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [GHR_BITS-1:0] arch_ghr_q, arch_ghr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_taken_q, rsp_taken_d;
  logic [IDX_BITS-1:0] rsp_idx_q, rsp_idx_d;
  logic [GHR_BITS-1:0] rsp_ghr_q, rsp_ghr_d;

  assign pred_idx = IDX_BITS'(gshare_index(pred_pc, 32'(spec_ghr_q), IDX_BITS));

  gshare_bht #(
    .IDX_BITS (IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_bht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (pred_idx),
    .rd_taken (pred_taken),
    .wr_en    (upd_valid),
    .wr_idx   (upd_idx),
    .wr_taken (upd_taken)
  );

  always_comb begin
    arch_ghr_d = arch_ghr_q;
    if (upd_valid) begin
      arch_ghr_d = GHR_BITS'({arch_ghr_q, upd_taken});
    end
    // Repair beats flush beats the speculative shift; flush takes this cycle's arch update.
    spec_ghr_d = spec_ghr_q;
    if (upd_valid && upd_mispredict) begin
      spec_ghr_d = GHR_BITS'({upd_ghr, upd_taken});
    end else if (flush) begin
      spec_ghr_d = arch_ghr_d;
    end else if (pred_valid) begin
      spec_ghr_d = GHR_BITS'({spec_ghr_q, pred_taken});
    end
  end

  always_comb begin
    rsp_valid_d = pred_valid;
    rsp_taken_d = rsp_taken_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_ghr_d   = rsp_ghr_q;
    if (pred_valid) begin
      rsp_taken_d = pred_taken;
      rsp_idx_d   = pred_idx;
      rsp_ghr_d   = spec_ghr_q;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      spec_ghr_q  <= '0;
      arch_ghr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_taken_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_ghr_q   <= '0;
    end else begin
      spec_ghr_q  <= spec_ghr_d;
      arch_ghr_q  <= arch_ghr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_taken_q <= rsp_taken_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_ghr_q   <= rsp_ghr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_taken = rsp_taken_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_ghr   = rsp_ghr_q;

`ifdef GSHARE_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_mispred_d  = perf_mispred_q;
    if (upd_valid && (perf_branches_q != 32'hFFFF_FFFF)) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end
    if (upd_valid && upd_mispredict && (perf_mispred_q != 32'hFFFF_FFFF)) begin
      perf_mispred_d = perf_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_mispred  = perf_mispred_q;
`endif

endmodule
